// File: rtl/sifh_hist_peak.sv
// Single-photon histogram: clears a 2^(PIX_W+NB)-entry external RAM, accumulates
// timestamps by read-modify-write, then reports the peak bin of every pixel.
// Latency: accepted ts -> RAM commit 3 cycles; last ren -> last peak_valid 2 cycles.
// Backpressure: ts_ready is high only in ACCUM, so no other state accepts a timestamp.
//
// Ports:
//   clk, res          clock, asynchronous active-high reset
//   start, frame_end  frame control pulses (start ignored while busy,
//                     frame_end ignored outside ACCUM)
//   ts_valid/ts_ready timestamp handshake; ts_data, ts_pixel select {pixel, bin}
//   waddr/wen/wdata   RAM write port A
//   raddr/ren/rdata   RAM read port B; rdata is valid one cycle after ren
//   peak_*            per-pixel result, peak_valid pulses once per pixel
//   busy              high in every state except IDLE
module sifh_hist_peak #(
   parameter int NP          = 10,
   parameter int NB          = 4,
   parameter int PIX_W       = 1,
   parameter int CW          = 8,
   parameter int CLR_ON_READ = 1
) (
   input  logic                  clk,
   input  logic                  res,
   input  logic                  start,
   input  logic                  frame_end,
   input  logic                  ts_valid,
   output logic                  ts_ready,
   input  logic [NP-1:0]         ts_data,
   input  logic [PIX_W-1:0]      ts_pixel,
   output logic [PIX_W+NB-1:0]   waddr,
   output logic [PIX_W+NB-1:0]   raddr,
   output logic                  wen,
   output logic                  ren,
   output logic [CW-1:0]         wdata,
   input  logic [CW-1:0]         rdata,
   output logic                  peak_valid,
   output logic [PIX_W-1:0]      peak_pixel,
   output logic [NB-1:0]         peak_bin,
   output logic [CW-1:0]         peak_count,
   output logic                  busy
);

   localparam int AW = PIX_W + NB;
   localparam logic [AW-1:0] AMAX = '1;
   localparam logic [NB-1:0] BMAX = '1;
   localparam logic [CW-1:0] CMAX = '1;
   localparam bit            COR  = (CLR_ON_READ != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_DRAIN,
      S_SEARCH,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic          ram_clean;

   // accumulate pipeline: stage 1 = read issued, stage 2 = rdata present
   logic          acc1_vld, acc2_vld;
   // search pipeline, same two stages
   logic          srd1_vld, srd2_vld;
   logic [AW-1:0] s2_addr;

   // write issued one cycle before the one currently on the port
   logic          wh_vld;
   logic [AW-1:0] wh_addr;
   logic [CW-1:0] wh_dat;

   // search sweep
   logic [AW-1:0] scnt;
   logic          issue_done;
   logic [CW-1:0] run_cnt;
   logic [NB-1:0] run_bin;

   logic          accept;
   logic [AW-1:0] acc_addr;
   logic [CW-1:0] cur;
   logic [CW-1:0] inc;
   logic [NB-1:0] s_bin;
   logic [CW-1:0] cand_cnt;
   logic [NB-1:0] cand_bin;

   assign ts_ready = (state == S_ACCUM);
   assign busy     = (state != S_IDLE);
   assign accept   = (state == S_ACCUM) && ts_valid;
   assign acc_addr = {ts_pixel, ts_data[NP-1 -: NB]};

   // Timestamp bits below the bin field do not affect the histogram.
   generate
      if (NB < NP) begin : g_unused_ts
         logic unused_ts_lsb;
         assign unused_ts_lsb = ^ts_data[NP-NB-1:0];
      end
   endgenerate

   // The RAM read for a stage-2 entry happened before the two most recent
   // writes had committed, so either of them may hold fresher data than
   // rdata. The write on the port right now is the newest and wins.
   always_comb begin
      cur = rdata;
      if (wh_vld && (wh_addr == s2_addr)) cur = wh_dat;
      if (wen && (waddr == s2_addr))      cur = wdata;
      inc = (cur == CMAX) ? CMAX : cur + CW'(1);
   end

   // Running max per pixel. Bin 0 restarts the max; later bins replace it
   // only when strictly greater, so ties keep the lowest bin.
   always_comb begin
      s_bin    = s2_addr[NB-1:0];
      cand_cnt = run_cnt;
      cand_bin = run_bin;
      if ((s_bin == '0) || (rdata > run_cnt)) begin
         cand_cnt = rdata;
         cand_bin = s_bin;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = (COR && ram_clean) ? S_ACCUM : S_CLEAR;
         S_CLEAR:  if (waddr == AMAX) state_nxt = S_ACCUM;
         S_ACCUM:  if (frame_end) state_nxt = S_DRAIN;
         // Once both read stages are empty only the final write remains; it
         // commits on the exit edge, well before the first search read.
         S_DRAIN:  if (!acc1_vld && !acc2_vld) state_nxt = S_SEARCH;
         S_SEARCH: if (srd2_vld && (s2_addr == AMAX)) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state      <= S_IDLE;
         ram_clean  <= 1'b0;
         acc1_vld   <= 1'b0;
         acc2_vld   <= 1'b0;
         srd1_vld   <= 1'b0;
         srd2_vld   <= 1'b0;
         s2_addr    <= '0;
         wh_vld     <= 1'b0;
         wh_addr    <= '0;
         wh_dat     <= '0;
         scnt       <= '0;
         issue_done <= 1'b0;
         run_cnt    <= '0;
         run_bin    <= '0;
         ren        <= 1'b0;
         raddr      <= '0;
         wen        <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         peak_valid <= 1'b0;
         peak_pixel <= '0;
         peak_bin   <= '0;
         peak_count <= '0;
      end else begin
         state <= state_nxt;

         if (state == S_DONE)
            ram_clean <= COR;
         else if ((state_nxt == S_ACCUM) && (state != S_ACCUM))
            ram_clean <= 1'b0;

         // read port
         acc1_vld <= accept;
         srd1_vld <= 1'b0;
         ren      <= 1'b0;
         if (accept) begin
            ren   <= 1'b1;
            raddr <= acc_addr;
         end else if ((state == S_SEARCH) && !issue_done) begin
            ren      <= 1'b1;
            raddr    <= scnt;
            srd1_vld <= 1'b1;
            scnt     <= scnt + AW'(1);
            if (scnt == AMAX) issue_done <= 1'b1;
         end
         if (state == S_DRAIN) begin
            scnt       <= '0;
            issue_done <= 1'b0;
         end

         acc2_vld <= acc1_vld;
         srd2_vld <= srd1_vld;
         if (acc1_vld || srd1_vld) s2_addr <= raddr;

         // write port
         wh_vld  <= wen;
         wh_addr <= waddr;
         wh_dat  <= wdata;
         if ((state == S_IDLE) && (state_nxt == S_CLEAR)) begin
            // first clear write goes out with the start edge so CLEAR spans
            // exactly one cycle per address
            wen   <= 1'b1;
            waddr <= '0;
            wdata <= '0;
         end else if (state == S_CLEAR) begin
            wdata <= '0;
            if (waddr == AMAX) wen <= 1'b0;
            else               waddr <= waddr + AW'(1);
         end else if (acc2_vld) begin
            wen   <= 1'b1;
            waddr <= s2_addr;
            wdata <= inc;
         end else if (srd1_vld && COR) begin
            wen   <= 1'b1;
            waddr <= raddr;
            wdata <= '0;
         end else begin
            wen <= 1'b0;
         end

         // peak reporting
         peak_valid <= 1'b0;
         if (srd2_vld) begin
            run_cnt <= cand_cnt;
            run_bin <= cand_bin;
            if (s_bin == BMAX) begin
               peak_valid <= 1'b1;
               peak_pixel <= s2_addr[AW-1:NB];
               peak_bin   <= cand_bin;
               peak_count <= cand_cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_sifh_hist_peak.sv
module tb_sifh_hist_peak;

   localparam int NP = 10, NB = 4, PIX_W = 1, CW = 8;
   localparam int AW = PIX_W + NB;
   localparam int NPIX = 1 << PIX_W, NBIN = 1 << NB, NADDR = 1 << AW;
   localparam int CSAT = (1 << CW) - 1;

   logic clk = 1'b0;
   logic res = 1'b1;
   logic start = 1'b0, frame_end = 1'b0, ts_valid = 1'b0;
   logic ts_ready;
   logic [NP-1:0] ts_data = '0;
   logic [PIX_W-1:0] ts_pixel = '0;
   logic [AW-1:0] waddr, raddr;
   logic wen, ren;
   logic [CW-1:0] wdata;
   logic [CW-1:0] rdata = '0;
   logic peak_valid;
   logic [PIX_W-1:0] peak_pixel;
   logic [NB-1:0] peak_bin;
   logic [CW-1:0] peak_count;
   logic busy;

   always #5 clk = ~clk;

   sifh_hist_peak #(.NP(NP), .NB(NB), .PIX_W(PIX_W), .CW(CW), .CLR_ON_READ(1)) dut (
      .clk(clk), .res(res), .start(start), .frame_end(frame_end),
      .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data), .ts_pixel(ts_pixel),
      .waddr(waddr), .raddr(raddr), .wen(wen), .ren(ren), .wdata(wdata), .rdata(rdata),
      .peak_valid(peak_valid), .peak_pixel(peak_pixel), .peak_bin(peak_bin),
      .peak_count(peak_count), .busy(busy)
   );

   // dual-port RAM, read-first, registered read; starts with garbage
   logic [CW-1:0] mem [NADDR];
   bit seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < NADDR; i++) mem[i] <= CW'($urandom);
         seeded <= 1'b1;
      end else if (wen) begin
         mem[waddr] <= wdata;
      end
      if (ren) rdata <= mem[raddr];
   end

   typedef struct packed {
      logic [PIX_W-1:0] pix;
      logic [NB-1:0]    bin;
      logic [CW-1:0]    cnt;
   } res_t;

   res_t exp_q[$];
   res_t mon_e;
   int n_cmp = 0, n_bad = 0;

   int hist [NPIX][NBIN];
   int hq_pix[$], hq_bin[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every peak pulse is matched against the next expected result
   always @(negedge clk) begin
      if (!res && peak_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL peak_unexpected: got pixel %0d bin %0d count %0d, expected no result",
                     peak_pixel, peak_bin, peak_count);
         end else begin
            mon_e = exp_q.pop_front();
            chk("peak_pixel", 32'(peak_pixel), 32'(mon_e.pix));
            chk("peak_bin",   32'(peak_bin),   32'(mon_e.bin));
            chk("peak_count", 32'(peak_count), 32'(mon_e.cnt));
         end
      end
   end

   task automatic model_clear();
      for (int p = 0; p < NPIX; p++)
         for (int b = 0; b < NBIN; b++) hist[p][b] = 0;
   endtask

   // reference: saturate each count, pick the largest, lowest bin on ties
   task automatic push_expected();
      res_t r;
      int best, bbin, c;
      for (int p = 0; p < NPIX; p++) begin
         best = -1;
         bbin = 0;
         for (int b = 0; b < NBIN; b++) begin
            c = (hist[p][b] > CSAT) ? CSAT : hist[p][b];
            if (c > best) begin
               best = c;
               bbin = b;
            end
         end
         r.pix = PIX_W'(p);
         r.bin = NB'(bbin);
         r.cnt = CW'(best);
         exp_q.push_back(r);
      end
   endtask

   task automatic do_start(input bit expect_clear);
      model_clear();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (expect_clear) begin
         for (int i = 0; i < NADDR; i++) begin
            @(negedge clk);
            chk("clear_write", 32'({wen, waddr, wdata}), 32'({1'b1, AW'(i), CW'(0)}));
         end
      end
      @(negedge clk);
      chk("accum_ready", 32'({ts_ready, wen}), 32'(2'b10));
      @(posedge clk); #1;
   endtask

   task automatic run_hits(input bit gaps, input bit fe_last, input bit rnd_low);
      int p, b, n;
      while (hq_pix.size() > 0) begin
         p = hq_pix.pop_front();
         b = hq_bin.pop_front();
         ts_valid = 1'b1;
         ts_pixel = PIX_W'(p);
         ts_data  = NP'(b * (1 << (NP - NB)) +
                        (rnd_low ? int'($urandom_range(0, (1 << (NP - NB)) - 1)) : 0));
         if (fe_last && hq_pix.size() == 0) frame_end = 1'b1;
         hist[p][b]++;
         @(posedge clk); #1;
         ts_valid  = 1'b0;
         frame_end = 1'b0;
         if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin @(posedge clk); #1; end
         end
      end
      if (!fe_last) begin
         frame_end = 1'b1;
         @(posedge clk); #1;
         frame_end = 1'b0;
      end
      push_expected();
   endtask

   task automatic finish_frame();
      int k = 0;
      while (busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("frame_done_in_time", 32'(busy), 32'(0));
      chk("all_results_seen", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_ctl"}, 32'({ts_ready, wen, ren, busy, peak_valid}), 32'(0));
      chk({tag, "_addr"}, 32'({waddr, raddr}), 32'(0));
      chk({tag, "_wdata"}, 32'(wdata), 32'(0));
      chk({tag, "_peak"}, 32'({peak_pixel, peak_bin, peak_count}), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      @(posedge clk); #1;
      res = 1'b0;
      @(posedge clk); #1;

      // five back-to-back hits on pixel 0, bin 15 (ts 0x3C0); RAM starts dirty
      do_start(1'b1);
      for (int i = 0; i < 5; i++) begin hq_pix.push_back(0); hq_bin.push_back(15); end
      run_hits(1'b0, 1'b0, 1'b0);
      finish_frame();

      // clean restart; pixel 1 tie between bins 9 and 2, pixel 0 single hit
      do_start(1'b0);
      for (int i = 0; i < 3; i++) begin
         hq_pix.push_back(1); hq_bin.push_back(9);
         hq_pix.push_back(1); hq_bin.push_back(2);
      end
      hq_pix.push_back(0); hq_bin.push_back(7);
      run_hits(1'b0, 1'b0, 1'b1);
      finish_frame();

      // saturation: 300 hits on one bin, frame_end with the last hit
      do_start(1'b0);
      for (int i = 0; i < 300; i++) begin hq_pix.push_back(1); hq_bin.push_back(5); end
      run_hits(1'b0, 1'b1, 1'b1);
      finish_frame();

      // random frames, bins biased toward a few addresses to stress forwarding
      for (int f = 0; f < 6; f++) begin
         do_start(1'b0);
         n = $urandom_range(10, 60);
         for (int i = 0; i < n; i++) begin
            hq_pix.push_back($urandom_range(0, NPIX - 1));
            hq_bin.push_back(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3)
                                                         : $urandom_range(0, NBIN - 1));
         end
         run_hits(f[0], bit'($urandom_range(0, 1)), 1'b1);
         finish_frame();
      end

      // reset in the middle of accumulation
      do_start(1'b0);
      for (int i = 0; i < 4; i++) begin
         ts_valid = 1'b1;
         ts_pixel = PIX_W'($urandom_range(0, NPIX - 1));
         ts_data  = NP'($urandom);
         @(posedge clk); #1;
      end
      res = 1'b1;
      #1;
      check_outputs_zero("midreset");
      ts_valid = 1'b0;
      @(posedge clk); #1;
      res = 1'b0;
      @(posedge clk); #1;

      // after reset the frame must go through a full CLEAR again
      do_start(1'b1);
      for (int i = 0; i < 20; i++) begin
         hq_pix.push_back($urandom_range(0, NPIX - 1));
         hq_bin.push_back($urandom_range(0, NBIN - 1));
      end
      run_hits(1'b1, 1'b0, 1'b1);
      finish_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sifh_hist_peak.md
# sifh_hist_peak

Parametrised successor to the single-photon histogramming FSM. It owns one dual-port histogram RAM holding 2^PIX_W pixels × 2^NB bins. The block clears the RAM, then accumulates timestamps by read-modify-write with hazard forwarding and saturation. It then scans every pixel for its peak bin, optionally clearing each bin as it is read. It sits between the TDC timestamp stream and the depth-estimation stage.

## Interface
- NP, 10: timestamp width.
- NB, 4: bin-address width; bin = ts_data[NP-1 -: NB]; NB ≤ NP.
- PIX_W, 1: pixel-index width; PIXELS = 2^PIX_W.
- CW, 8: count width (RAM data width).
- CLR_ON_READ, 1: 1 = SEARCH writes 0 behind each read bin.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- res  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame.
- frame_end  in  1  one-cycle pulse; ends accumulation.
- ts_valid  in  1  timestamp valid.
- ts_ready  out  1  high only in ACCUM.
- ts_data  in  NP  timestamp.
- ts_pixel  in  PIX_W  pixel index of the timestamp.
- waddr / raddr  out  PIX_W+NB  RAM addresses {pixel, bin}.
- wen / ren  out  1  RAM port-A write enable / port-B read enable.
- wdata  out  CW  RAM write data.
- rdata  in  CW  RAM read data; valid one cycle after ren.
- peak_valid  out  1  one-cycle pulse per pixel result.
- peak_pixel  out  PIX_W, peak_bin  out  NB, peak_count  out  CW.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, SEARCH, DONE.
- IDLE: start → CLEAR. If CLR_ON_READ=1 and ram_clean=1, start → ACCUM instead.
- CLEAR: wen=1, wdata=0, waddr counts 0 … 2^(PIX_W+NB)−1, one address per cycle. After the last address → ACCUM.
- ACCUM: ts_ready=1. On ts_valid&ts_ready, the address is {ts_pixel, bin}.
  - Read is issued; written value = sat(current)+1. Saturation holds at 2^CW−1.
  - current is forwarded from any in-flight write (up to 2) to the same address, newest first. Otherwise current = rdata.
  - frame_end → DRAIN. A timestamp accepted in the same cycle as frame_end is counted.
- DRAIN: ts_ready=0. Wait until the pipeline is empty (no pending writes) → SEARCH.
- SEARCH: ren sweeps addresses 0 … max in order.
  - Per pixel, the running max is updated only on a strictly greater count, so ties go to the lowest bin.
  - After a pixel's last bin returns, peak_valid pulses with that pixel's result. Pixels are reported in ascending order.
  - If CLR_ON_READ=1, each read address gets a write of 0 one cycle later.
  - After the last pixel → DONE.
- DONE: one cycle → IDLE. Sets ram_clean = CLR_ON_READ.
- ram_clean is cleared on reset and on entry to ACCUM.
- start while busy is ignored. frame_end outside ACCUM is ignored.

## Timing
- Reset (asynchronous): state=IDLE, ram_clean=0.
  - All outputs 0: ts_ready, wen, ren, waddr, raddr, wdata, peak_*, busy.
  - RAM contents are then undefined; the next start always goes through CLEAR.
- CLEAR lasts 2^(PIX_W+NB) cycles.
- Accumulate latency:
  - Acceptance edge E: raddr/ren registered at E.
  - rdata available after E+1.
  - wen/waddr/wdata registered at E+2; RAM commits at E+3.
- Throughput: one timestamp per cycle, including back-to-back hits to the same bin.
- DRAIN: at most 3 cycles.
- SEARCH: 2^(PIX_W+NB) read cycles. Last peak_valid occurs 2 cycles after the last ren.
- peak_* outputs hold their value between pulses.

## Test plan
- Reset, start, then wait: 32 consecutive wen cycles with wdata=0 and waddr 0..31, then ts_ready=1.
- 5 back-to-back timestamps, ts_pixel=0, ts_data=0x3C0 (bin 15), then frame_end → pixel 0 reports peak_bin=15, peak_count=5. Pixel 1 reports peak_bin=0, peak_count=0.
- Pixel 1: 3 hits on bin 2, 3 hits on bin 9, interleaved → peak_bin=2, peak_count=3 (lowest-bin tie rule).
- 300 hits on one bin with CW=8 → peak_count=255; no wraparound.
- CLR_ON_READ=1: first frame completes. Second start → ts_ready=1 on the next cycle with no CLEAR. A single hit then reports count 1.
- Assert res mid-ACCUM → all outputs 0 immediately. The next start performs a full 32-cycle CLEAR.
